cmp_seq: RTL and testbench
==========================

Name: cmp_seq

Overview:
Parametrised, multi-cycle magnitude comparator. It is the sequential successor of the 8-bit combinational comparator. It compares two WIDTH-bit operands DIGIT bits per clock, MSB digit first, and stops early at the first differing digit. It supports unsigned and two's-complement signed modes and uses a start/busy/done handshake. It sits beside datapath units that need wide compares without a long combinational chain.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT digits per compare.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a compare; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
ci  input  1  cascade equal-in; captured with the operands
signed_mode  input  1  1 = two's-complement compare; captured with the operands
busy  output  1  high while a compare is in progress (state RUN)
done  output  1  one-cycle pulse: results are valid and newly updated
gt  output  1  A > B
lt  output  1  A < B
eq  output  1  A == B and ci == 1

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Everything is registered on the rising edge of clk.
- Reset: state goes to IDLE. busy, done, gt, lt and eq are all 0. Operand registers are cleared.
- Reset has priority over all other inputs. Reset mid-RUN abandons the compare; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture a, b, ci and signed_mode.
  - Set the digit index to NDIG-1 (the MSB digit) and go to RUN.
  - gt, lt and eq keep their previous values.
- RUN: on each edge, compare digit i of the captured A and B.
  - Unsigned mode, or any digit other than the MSB digit: plain unsigned compare.
  - Signed mode, MSB digit only: invert the top bit of both digits, then compare unsigned. This is equivalent to a signed compare.
  - Digits differ: load gt/lt from the digit compare, clear eq, go to DONE.
  - Digits equal and i == 0: set gt=0, lt=0, eq=ci, go to DONE.
  - Digits equal and i > 0: decrement i and stay in RUN.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Outputs:
  - busy = (state == RUN).
  - done = (state == DONE).
  - gt/lt/eq are updated on entry to DONE and held until the next DONE or a reset.
  - At most one of gt/lt/eq is ever 1.
  - gt=lt=eq=0 is legal: it means the operands are equal and ci was 0.
- Latency: let the start edge be edge 0 and k the 1-based position of the first differing digit, counted from the MSB.
  - done is high in the cycle after edge k.
  - If all digits are equal, k = NDIG.
  - Minimum latency is 1 cycle; maximum is NDIG cycles.
- Start handling:
  - start is accepted only in IDLE.
  - start during RUN or DONE is ignored and not queued.
  - Back-to-back throughput is one compare per (k+2) cycles.
- Operand stability: a, b, ci and signed_mode may change freely after the start edge; only the captured values are used.
- Boundaries:
  - Most-negative vs most-positive in signed mode resolves at the MSB digit.
  - DIGIT == WIDTH gives a single-cycle RUN.
  - X on the inputs is not checked.

Test Plan:
1. Defaults (WIDTH=32, DIGIT=4). a=b=0x0000_0001, ci=1, unsigned, pulse start -> busy for 8 cycles; done 8 cycles after the start edge; eq=1, gt=0, lt=0.
2. a=0x8000_0000, b=0x7FFF_FFFF, unsigned -> done 1 cycle after start, gt=1. Repeat with signed_mode=1 -> done after 1 cycle, lt=1.
3. a=0x1234_5670, b=0x1234_5671, signed -> done after 8 cycles, lt=1. Then a=0x1244_0000, b=0x1234_FFFF -> done after 3 cycles, gt=1.
4. a=b=0xFFFF_FFFF, ci=0 -> done after 8 cycles, gt=lt=eq=0. Then repeat with ci=1 -> eq=1.
5. Start a compare of equal operands. Assert rst on the 3rd RUN cycle -> next cycle busy=0, done=0, gt/lt/eq=0, and no done pulse follows. A new start after reset completes normally.
6. Hold start high continuously, change a/b during RUN, and pulse start during DONE -> results match the operands captured at the first start; the next compare begins only from IDLE; done pulses never occur on consecutive cycles.

Source files
------------

// File: rtl/cmp_seq_if.sv
// cmp_seq_if: start/busy/done handshake and result bus
// for the multi-cycle magnitude comparator.
interface cmp_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start,
    output a,
    output b,
    output ci,
    output signed_mode,
    input  busy,
    input  done,
    input  gt,
    input  lt,
    input  eq
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  ci,
    input  signed_mode,
    output busy,
    output done,
    output gt,
    output lt,
    output eq
  );
endinterface

// File: rtl/cmp_seq.sv
// cmp_seq: digit-serial magnitude comparator, MSB digit first,
// early exit on the first differing digit, unsigned or signed.
module cmp_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  cmp_seq_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [NDIG-1:0][DIGIT-1:0] dig_vec_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  dig_vec_t      a_q, a_d;
  dig_vec_t      b_q, b_d;
  logic          ci_q, ci_d;
  logic          sm_q, sm_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic          eq_q, eq_d;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic             flip;
  logic             dgt;
  logic             dlt;

  // Current digit pair; in signed mode the MSB digit has its
  // sign bit flipped so an unsigned compare orders it correctly.
  always_comb begin
    flip = sm_q && (idx_q == MSB_IDX);
    da   = a_q[idx_q];
    db   = b_q[idx_q];
    da[DIGIT-1] = da[DIGIT-1] ^ flip;
    db[DIGIT-1] = db[DIGIT-1] ^ flip;
    dgt  = (da > db);
    dlt  = (da < db);
  end

  // Next-state and result update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    sm_d    = sm_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = dig_vec_t'(bus.a);
          b_d     = dig_vec_t'(bus.b);
          ci_d    = bus.ci;
          sm_d    = bus.signed_mode;
          idx_d   = MSB_IDX;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dgt || dlt) begin
          gt_d    = dgt;
          lt_d    = dlt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = ci_q;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      sm_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      sm_q    <= sm_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;

  // The three result flags are mutually exclusive.
  a_onehot_flags: assert property (
    @(posedge clk) $onehot0({gt_q, lt_q, eq_q})
  );

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: scoreboard bench for cmp_seq,
// one task per scenario, WIDTH=32 DIGIT=4.
module tb_cmp_seq;

  localparam int W    = 32;
  localparam int D    = 4;
  localparam int NDIG = W / D;

  typedef struct {
    logic g;
    logic l;
    logic e;
    int   k;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  cmp_seq_if #(.WIDTH(W)) bus ();

  cmp_seq #(
    .WIDTH(W),
    .DIGIT(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci,
    input logic         sm
  );
    exp_t r;
    r.k = NDIG;
    for (int i = 0; i < NDIG; i++)
      if (a[i*D +: D] != b[i*D +: D]) r.k = NDIG - i;
    if (sm) begin
      r.g = ($signed(a) > $signed(b));
      r.l = ($signed(a) < $signed(b));
    end else begin
      r.g = (a > b);
      r.l = (a < b);
    end
    r.e = (a == b) && ci;
    return r;
  endfunction

  task automatic issue(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci,
    input logic         sm
  );
    sb.push_back(model(a, b, ci, sm));
    bus.a           = a;
    bus.b           = b;
    bus.ci          = ci;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start       = 1'b0;
    bus.a           = W'($urandom);
    bus.b           = W'($urandom);
    bus.ci          = 1'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  task automatic wait_done(
    output int         n,
    output int         nb,
    output logic [2:0] f,
    output logic       dn,
    output logic       ok
  );
    n  = 0;
    nb = 0;
    ok = 1'b1;
    while (bus.done !== 1'b1 && ok) begin
      if (bus.busy === 1'b1) nb++;
      if (n >= 4 * NDIG) ok = 1'b0;
      else begin
        @(negedge clk);
        n++;
      end
    end
    f = {bus.gt, bus.lt, bus.eq};
    @(negedge clk);
    dn = bus.done;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '1;
    bus.b     = '0;
    bus.ci    = 1'b1;
    bus.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=00000",
        {bus.busy, bus.done, bus.gt, bus.lt, bus.eq});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_eq;
    int n, nb;
    logic [2:0] f;
    logic dn, ok;
    exp_t x;
    issue(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0);
    wait_done(n, nb, f, dn, ok);
    x = sb.pop_front();
    n_chk++;
    if (!ok || n !== x.k) begin
      n_fail++;
      $display("FAIL eq_latency got=%0d exp=%0d ok=%b", n, x.k, ok);
    end
    n_chk++;
    if (nb !== x.k) begin
      n_fail++;
      $display("FAIL eq_busy_cycles got=%0d exp=%0d", nb, x.k);
    end
    n_chk++;
    if (f !== {x.g, x.l, x.e}) begin
      n_fail++;
      $display("FAIL eq_flags got=%b exp=%b", f, {x.g, x.l, x.e});
    end
    n_chk++;
    if (dn !== 1'b0) begin
      n_fail++;
      $display("FAIL eq_done_width got=%b exp=0", dn);
    end
  endtask

  task automatic test_msb;
    int n, nb;
    logic [2:0] f;
    logic dn, ok;
    exp_t x;
    for (int s = 0; s < 2; s++) begin
      issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'(s));
      wait_done(n, nb, f, dn, ok);
      x = sb.pop_front();
      n_chk++;
      if (!ok || n !== x.k) begin
        n_fail++;
        $display("FAIL msb_latency s=%0d got=%0d exp=%0d", s, n, x.k);
      end
      n_chk++;
      if (f !== {x.g, x.l, x.e}) begin
        n_fail++;
        $display("FAIL msb_flags s=%0d got=%b exp=%b",
          s, f, {x.g, x.l, x.e});
      end
    end
  endtask

  task automatic test_signed;
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    int n, nb;
    logic [2:0] f;
    logic dn, ok;
    exp_t x;
    av[0] = 32'h1234_5670; bv[0] = 32'h1234_5671;
    av[1] = 32'h1244_0000; bv[1] = 32'h1234_FFFF;
    av[2] = 32'hFFFF_FFF0; bv[2] = 32'h0000_0005;
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i], 1'b1, 1'b1);
      wait_done(n, nb, f, dn, ok);
      x = sb.pop_front();
      n_chk++;
      if (!ok || n !== x.k) begin
        n_fail++;
        $display("FAIL signed_latency i=%0d got=%0d exp=%0d", i, n, x.k);
      end
      n_chk++;
      if (f !== {x.g, x.l, x.e}) begin
        n_fail++;
        $display("FAIL signed_flags i=%0d got=%b exp=%b",
          i, f, {x.g, x.l, x.e});
      end
    end
  endtask

  task automatic test_ci;
    int n, nb;
    logic [2:0] f;
    logic dn, ok;
    exp_t x;
    for (int c = 0; c < 2; c++) begin
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'(c), 1'b0);
      wait_done(n, nb, f, dn, ok);
      x = sb.pop_front();
      n_chk++;
      if (!ok || n !== x.k) begin
        n_fail++;
        $display("FAIL ci_latency c=%0d got=%0d exp=%0d", c, n, x.k);
      end
      n_chk++;
      if (f !== {x.g, x.l, x.e}) begin
        n_fail++;
        $display("FAIL ci_flags c=%0d got=%b exp=%b",
          c, f, {x.g, x.l, x.e});
      end
    end
  endtask

  task automatic test_reset_mid;
    int n, nb, nd;
    logic [2:0] f;
    logic dn, ok;
    exp_t x;
    bus.a = 32'hA5A5_A5A5;
    bus.b = 32'hA5A5_A5A5;
    bus.ci = 1'b1;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({bus.busy, bus.done, bus.gt, bus.lt, bus.eq} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs got=%b exp=00000",
        {bus.busy, bus.done, bus.gt, bus.lt, bus.eq});
    end
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    n_chk++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_done got=%0d exp=0", nd);
    end
    issue(32'h0000_00F0, 32'h0000_0F00, 1'b1, 1'b0);
    wait_done(n, nb, f, dn, ok);
    x = sb.pop_front();
    n_chk++;
    if (!ok || n !== x.k || f !== {x.g, x.l, x.e}) begin
      n_fail++;
      $display("FAIL midrst_restart got=%0d/%b exp=%0d/%b",
        n, f, x.k, {x.g, x.l, x.e});
    end
  endtask

  task automatic test_back_to_back;
    exp_t e1, e2, x;
    logic prev;
    int nd;
    e1 = model(32'h1500_0000, 32'h1400_0000, 1'b1, 1'b0);
    sb.push_back(e1);
    bus.a = 32'h1500_0000;
    bus.b = 32'h1400_0000;
    bus.ci = 1'b1;
    bus.signed_mode = 1'b0;
    bus.start = 1'b1;
    prev = 1'b0;
    nd = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        nd++;
        n_chk++;
        if (prev !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_consecutive_done cyc=%0d", cyc);
        end
        x = sb.pop_front();
        n_chk++;
        if (cyc !== x.k || {bus.gt, bus.lt, bus.eq} !== {x.g, x.l, x.e}) begin
          n_fail++;
          $display("FAIL b2b_result cyc=%0d got=%b exp_cyc=%0d exp=%b",
            cyc, {bus.gt, bus.lt, bus.eq}, x.k, {x.g, x.l, x.e});
        end
      end
      prev = bus.done;
      if (cyc == 0) begin
        bus.a = 32'h0000_0100;
        bus.b = 32'h0000_0200;
        bus.signed_mode = 1'b1;
        e2 = model(32'h0000_0100, 32'h0000_0200, 1'b1, 1'b1);
        e2.k = e1.k + 2 + e2.k;
        sb.push_back(e2);
      end
      if (cyc == e1.k + 2) begin
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
    end
    n_chk++;
    if (nd !== 2 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d left=%0d exp=2/0", nd, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned_eq();
    test_msb();
    test_signed();
    test_ci();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
